core_request_port: RTL and testbench
====================================

Name: core_request_port

Overview:
Per-core request agent that sits directly upstream of butterfly_network, one instance per network input port.
- Accepts one memory request from a core and formats it into a network packet using `MAKE_PACKET.
- Tracks the return path: back packet, module NACK, switch drop, and timeout.
- On failure it re-issues the packet with its priority raised by one, saturating, until success or retry exhaustion.
- Reports completion, latency and statistics back to the core. This is the hardware equivalent of the per-core issue/retry loop the network bench runs today.

Parameters:
PACKET_W, `PACKET_W, forward packet width
BACK_PACKET_W, `BACK_PACKET_W, return packet width
DATA_WIDTH, `DATA_WIDTH, data field width
PRI_BITS, `PRI_BITS, priority field width
MOD_ID_BITS, `MOD_ID_BITS, module id width
LOCAL_ADDR_BITS, `LOCAL_ADDR_BITS, local address width
CORE_ID_BITS, `CORE_ID_BITS, core id width
CORE_ID, 0, constant core id stamped into every packet
MAX_RETRIES, 15, re-issues allowed before giving up
TIMEOUT, 64, WAIT cycles with no back packet and no drop before a retry; 0 disables the timeout
LAT_W, 16, width of the latency and statistic counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE
req_rw  in  1  1=write, 0=read
req_mod_id  in  MOD_ID_BITS  target module
req_local_addr  in  LOCAL_ADDR_BITS  local address
req_data  in  DATA_WIDTH  write data
net_pkt  out  PACKET_W  packet to network in_flat slice
net_valid  out  1  to network valid_in bit
net_back_pkt  in  BACK_PACKET_W  network out_flat slice
net_back_valid  in  1  network valid_back_out bit
net_dropped  in  1  network dropped_core_bus bit
resp_valid  out  1  one-cycle completion pulse
resp_ok  out  1  1=success, 0=gave up
resp_data  out  DATA_WIDTH  `BACK_PKT_DATA of the successful back packet, 0 on give-up
resp_latency  out  LAT_W  cycles spent in ISSUE+WAIT for this request
stat_retries  out  LAT_W  total re-issues since reset, saturating
stat_failures  out  LAT_W  total give-ups since reset, saturating

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, req_ready=1, net_valid=0, net_pkt=0, resp_*=0, stat_*=0, internal pri/retry/latency/timeout counters=0. Reset is asynchronous: outputs clear immediately, not at the next edge.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - When req_valid && req_ready at an edge: latch rw/mod/addr/data, clear pri, retry count and latency, then go to ISSUE.
- ISSUE
  - Lasts exactly one cycle.
  - Drives net_valid=1 and net_pkt=`MAKE_PACKET(rw, mod, addr, pri, data, CORE_ID).
  - Then goes to WAIT and clears the timeout counter.
  - net_valid is 0 in every other state, and net_pkt returns to 0.
- WAIT, evaluated each edge in this priority order:
  1. net_back_valid && `BACK_PKT_SUC: go to RESP with ok=1 and capture the data.
  2. net_back_valid && !SUC (module NACK), or net_dropped (switch drop), or the timeout counter reaching TIMEOUT-1 with TIMEOUT≠0: this is a failure event.
     - If retries==MAX_RETRIES: go to RESP with ok=0 and increment stat_failures.
     - Otherwise: pri = (pri==all-ones) ? pri : pri+1, increment retries and stat_retries, go to ISSUE.
  3. Otherwise stay in WAIT and increment the timeout counter.
- Back valid with success and net_dropped in the same cycle counts as success. Back valid with NACK and drop in the same cycle counts as one failure, not two.
- RESP
  - Lasts one cycle: resp_valid=1 plus resp_ok/resp_data/resp_latency, then IDLE.
  - The response fields hold their values until the next RESP. There is no backpressure on resp.
- Latency counter
  - Increments on every edge while the state is ISSUE or WAIT, and saturates at all-ones.
  - A single-shot success whose back packet is sampled k cycles after the ISSUE cycle gives resp_latency=k+1.
- Stray inputs: net_back_valid or net_dropped in IDLE, ISSUE or RESP are ignored with no state change. req_valid outside IDLE is not accepted.
- Minimum turnaround: a new request can be accepted one cycle after resp_valid, so there are 4 cycles between issue pulses of back-to-back single-shot requests with a 1-cycle network.
- Reset during ISSUE or WAIT abandons the request with no response and no stat update. A back packet arriving after reset is ignored because the block is in IDLE.

Test Plan:
1. Read, rw=0 mod=3 addr=0x12, SUC back packet 3 cycles after the issue pulse -> one net_valid pulse with pri=0 and core id=CORE_ID; then resp_valid for 1 cycle, ok=1, resp_data=back data, resp_latency=4; stat_retries=0.
2. Write with two NACK back packets, then SUC -> three net_valid pulses with pri 0, 1, 2 and identical other fields; resp_ok=1; stat_retries=2.
3. MAX_RETRIES=4, PRI_BITS=2, NACK every time -> five pulses with pri 0, 1, 2, 3, 3; after the 5th NACK resp_ok=0, resp_data=0; stat_failures=1, stat_retries=4.
4. net_dropped alone in WAIT -> re-issue next cycle with pri+1. net_dropped together with a SUC back packet -> success, no re-issue, stat_retries unchanged.
5. TIMEOUT=8, network silent -> re-issue after 8 WAIT cycles with pri=1. With TIMEOUT=0 and a silent network, the block stays in WAIT for 200 cycles with no pulse.
6. Assert rst mid-WAIT -> net_valid=0, resp_valid=0, req_ready=1 immediately. A SUC back packet 2 cycles after reset release produces no resp_valid, and the next request is issued with pri=0.

Source files
------------

// File: rtl/core_request_port_if.sv
// Core-side request/response and network-side forward/return signals of one core_request_port.
// master = core + network environment, slave = the request port itself.
interface core_request_port_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int PRI_BITS        = 3,
    parameter int MOD_ID_BITS     = 2,
    parameter int LOCAL_ADDR_BITS = 8,
    parameter int CORE_ID_BITS    = 2,
    parameter int LAT_W           = 16,
    parameter int PACKET_W        = 1 + MOD_ID_BITS + LOCAL_ADDR_BITS + PRI_BITS + DATA_WIDTH + CORE_ID_BITS,
    parameter int BACK_PACKET_W   = 1 + DATA_WIDTH
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_rw;
    logic [MOD_ID_BITS-1:0]     req_mod_id;
    logic [LOCAL_ADDR_BITS-1:0] req_local_addr;
    logic [DATA_WIDTH-1:0]      req_data;

    logic [PACKET_W-1:0]        net_pkt;
    logic                       net_valid;
    logic [BACK_PACKET_W-1:0]   net_back_pkt;
    logic                       net_back_valid;
    logic                       net_dropped;

    logic                       resp_valid;
    logic                       resp_ok;
    logic [DATA_WIDTH-1:0]      resp_data;
    logic [LAT_W-1:0]           resp_latency;
    logic [LAT_W-1:0]           stat_retries;
    logic [LAT_W-1:0]           stat_failures;

    modport master (
        output req_valid, req_rw, req_mod_id, req_local_addr, req_data,
        output net_back_pkt, net_back_valid, net_dropped,
        input  req_ready, net_pkt, net_valid,
        input  resp_valid, resp_ok, resp_data, resp_latency, stat_retries, stat_failures
    );

    modport slave (
        input  req_valid, req_rw, req_mod_id, req_local_addr, req_data,
        input  net_back_pkt, net_back_valid, net_dropped,
        output req_ready, net_pkt, net_valid,
        output resp_valid, resp_ok, resp_data, resp_latency, stat_retries, stat_failures
    );
endinterface

// File: rtl/core_request_port.sv
// Per-core request agent: issues one request into the network, retries with rising priority on NACK/drop/timeout.
// One request in flight; req_ready only in IDLE, response is a one-cycle pulse with no backpressure.
module core_request_port #(
    parameter int DATA_WIDTH      = 8,
    parameter int PRI_BITS        = 3,
    parameter int MOD_ID_BITS     = 2,
    parameter int LOCAL_ADDR_BITS = 8,
    parameter int CORE_ID_BITS    = 2,
    parameter int PACKET_W        = 1 + MOD_ID_BITS + LOCAL_ADDR_BITS + PRI_BITS + DATA_WIDTH + CORE_ID_BITS,
    parameter int BACK_PACKET_W   = 1 + DATA_WIDTH,
    parameter int CORE_ID         = 0,
    parameter int MAX_RETRIES     = 15,
    parameter int TIMEOUT         = 64,
    parameter int LAT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    core_request_port_if.slave   port
);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RTY_W-1:0]        RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [TMO_W-1:0]        TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
    localparam logic [CORE_ID_BITS-1:0] CID      = CORE_ID_BITS'(CORE_ID);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                     state_q, state_d;
    logic                       rw_q, rw_d;
    logic [MOD_ID_BITS-1:0]     mod_q, mod_d;
    logic [LOCAL_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [PRI_BITS-1:0]        pri_q, pri_d;
    logic [RTY_W-1:0]           retry_q, retry_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic [LAT_W-1:0]           lat_q, lat_d, lat_inc;

    logic                       req_ready_q, req_ready_d;
    logic                       net_valid_q, net_valid_d;
    logic [PACKET_W-1:0]        net_pkt_q, net_pkt_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_ok_q, resp_ok_d;
    logic [DATA_WIDTH-1:0]      resp_data_q, resp_data_d;
    logic [LAT_W-1:0]           resp_lat_q, resp_lat_d;
    logic [LAT_W-1:0]           stat_rty_q, stat_rty_d;
    logic [LAT_W-1:0]           stat_fail_q, stat_fail_d;

    logic back_suc, fail_evt;

    // Forward packet layout, MSB first: {rw, mod_id, local_addr, pri, data, core_id}.
    function automatic logic [PACKET_W-1:0] make_packet(
        input logic                       rw,
        input logic [MOD_ID_BITS-1:0]     mod,
        input logic [LOCAL_ADDR_BITS-1:0] addr,
        input logic [PRI_BITS-1:0]        pri,
        input logic [DATA_WIDTH-1:0]      data
    );
        return {rw, mod, addr, pri, data, CID};
    endfunction

    // Return packet layout: {suc, data}.
    assign back_suc = port.net_back_valid && port.net_back_pkt[BACK_PACKET_W-1];
    assign fail_evt = (port.net_back_valid && !port.net_back_pkt[BACK_PACKET_W-1])
                   || port.net_dropped
                   || ((TIMEOUT != 0) && (tmo_q == TMO_LAST));
    assign lat_inc  = (&lat_q) ? lat_q : lat_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        mod_d       = mod_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pri_d       = pri_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        lat_d       = lat_q;
        resp_ok_d   = resp_ok_q;
        resp_data_d = resp_data_q;
        resp_lat_d  = resp_lat_q;
        stat_rty_d  = stat_rty_q;
        stat_fail_d = stat_fail_q;

        unique case (state_q)
            IDLE: begin
                if (port.req_valid && req_ready_q) begin
                    rw_d    = port.req_rw;
                    mod_d   = port.req_mod_id;
                    addr_d  = port.req_local_addr;
                    data_d  = port.req_data;
                    pri_d   = '0;
                    retry_d = '0;
                    lat_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = lat_inc;
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_inc;
                if (back_suc) begin
                    state_d     = RESP;
                    resp_ok_d   = 1'b1;
                    resp_data_d = port.net_back_pkt[DATA_WIDTH-1:0];
                    resp_lat_d  = lat_inc;
                end else if (fail_evt) begin
                    if (retry_q == RTY_MAX) begin
                        state_d     = RESP;
                        resp_ok_d   = 1'b0;
                        resp_data_d = '0;
                        resp_lat_d  = lat_inc;
                        stat_fail_d = (&stat_fail_q) ? stat_fail_q : stat_fail_q + 1'b1;
                    end else begin
                        pri_d      = (&pri_q) ? pri_q : pri_q + 1'b1;
                        retry_d    = retry_q + 1'b1;
                        stat_rty_d = (&stat_rty_q) ? stat_rty_q : stat_rty_q + 1'b1;
                        state_d    = ISSUE;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        req_ready_d  = (state_d == IDLE);
        net_valid_d  = (state_d == ISSUE);
        resp_valid_d = (state_d == RESP);
        net_pkt_d    = net_valid_d ? make_packet(rw_d, mod_d, addr_d, pri_d, data_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rw_q         <= 1'b0;
            mod_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            pri_q        <= '0;
            retry_q      <= '0;
            tmo_q        <= '0;
            lat_q        <= '0;
            req_ready_q  <= 1'b1;
            net_valid_q  <= 1'b0;
            net_pkt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_lat_q   <= '0;
            stat_rty_q   <= '0;
            stat_fail_q  <= '0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            mod_q        <= mod_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            pri_q        <= pri_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            lat_q        <= lat_d;
            req_ready_q  <= req_ready_d;
            net_valid_q  <= net_valid_d;
            net_pkt_q    <= net_pkt_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_data_q  <= resp_data_d;
            resp_lat_q   <= resp_lat_d;
            stat_rty_q   <= stat_rty_d;
            stat_fail_q  <= stat_fail_d;
        end
    end

    assign port.req_ready     = req_ready_q;
    assign port.net_valid     = net_valid_q;
    assign port.net_pkt       = net_pkt_q;
    assign port.resp_valid    = resp_valid_q;
    assign port.resp_ok       = resp_ok_q;
    assign port.resp_data     = resp_data_q;
    assign port.resp_latency  = resp_lat_q;
    assign port.stat_retries  = stat_rty_q;
    assign port.stat_failures = stat_fail_q;
endmodule

// File: tb/tb_core_request_port.sv
// Bench for core_request_port: scripted network replies per attempt, outcome predicted from the retry rules.
module tb_core_request_port;
    localparam int DW = 8, MB = 2, AB = 8, CB = 2, LW = 16;
    localparam int PB0 = 2, MAXR0 = 4, TMO0 = 8, CID0 = 2;
    localparam int PB1 = 3, CID1 = 1;
    localparam int PMAX0 = (1 << PB0) - 1;
    localparam int PW0 = 1 + MB + AB + PB0 + DW + CB;
    localparam int PW1 = 1 + MB + AB + PB1 + DW + CB;

    localparam int K_SUC = 0, K_NACK = 1, K_DROP = 2, K_SIL = 3, K_DSUC = 4, K_NDROP = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_request_port_if #(.DATA_WIDTH(DW), .PRI_BITS(PB0), .MOD_ID_BITS(MB), .LOCAL_ADDR_BITS(AB),
                           .CORE_ID_BITS(CB), .LAT_W(LW)) b0 ();
    core_request_port_if #(.DATA_WIDTH(DW), .PRI_BITS(PB1), .MOD_ID_BITS(MB), .LOCAL_ADDR_BITS(AB),
                           .CORE_ID_BITS(CB), .LAT_W(LW)) b1 ();

    core_request_port #(.DATA_WIDTH(DW), .PRI_BITS(PB0), .MOD_ID_BITS(MB), .LOCAL_ADDR_BITS(AB),
                        .CORE_ID_BITS(CB), .CORE_ID(CID0), .MAX_RETRIES(MAXR0), .TIMEOUT(TMO0),
                        .LAT_W(LW)) u0 (.clk(clk), .rst(rst), .port(b0.slave));
    core_request_port #(.DATA_WIDTH(DW), .PRI_BITS(PB1), .MOD_ID_BITS(MB), .LOCAL_ADDR_BITS(AB),
                        .CORE_ID_BITS(CB), .CORE_ID(CID1), .MAX_RETRIES(15), .TIMEOUT(0),
                        .LAT_W(LW)) u1 (.clk(clk), .rst(rst), .port(b1.slave));

    int errors = 0;
    int checks = 0;
    int m_retries = 0;
    int m_failures = 0;

    int          a_kind [0:15];
    int          a_dly  [0:15];
    logic [DW-1:0] a_bd [0:15];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW0-1:0] pkt0(input logic rw, input logic [MB-1:0] m,
                                            input logic [AB-1:0] a, input int pri, input logic [DW-1:0] d);
        logic [PB0-1:0] p;
        logic [CB-1:0]  c;
        p = PB0'(pri);
        c = CB'(CID0);
        return {rw, m, a, p, d, c};
    endfunction

    function automatic logic [PW1-1:0] pkt1(input logic rw, input logic [MB-1:0] m,
                                            input logic [AB-1:0] a, input logic [DW-1:0] d);
        logic [PB1-1:0] p;
        logic [CB-1:0]  c;
        p = '0;
        c = CB'(CID1);
        return {rw, m, a, p, d, c};
    endfunction

    task automatic set_att(input int i, input int kind, input int dly, input logic [DW-1:0] bd);
        a_kind[i] = kind;
        a_dly[i]  = dly;
        a_bd[i]   = bd;
    endtask

    // Issues one request on u0 and plays the scripted network reply for each attempt.
    task automatic run_req(input logic rw, input logic [MB-1:0] m, input logic [AB-1:0] a,
                           input logic [DW-1:0] d, input string tag);
        int n, lat, w, k;
        bit ok, fin;
        logic [DW-1:0] rdata;
        n = 0; ok = 1'b0; lat = 0; rdata = '0;
        for (int i = 0; i <= MAXR0; i++) begin
            w   = (a_kind[i] == K_SIL) ? TMO0 - 1 : a_dly[i];
            lat = lat + w + 2;
            n   = i + 1;
            if (a_kind[i] == K_SUC || a_kind[i] == K_DSUC) begin
                ok = 1'b1;
                rdata = a_bd[i];
                break;
            end
        end
        m_retries  = m_retries + n - 1;
        m_failures = m_failures + (ok ? 0 : 1);

        chk({tag, "/ready"}, 64'(b0.req_ready), 64'(1));
        b0.req_valid = 1'b1; b0.req_rw = rw; b0.req_mod_id = m; b0.req_local_addr = a; b0.req_data = d;
        @(negedge clk);
        b0.req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            k = a_kind[i];
            chk($sformatf("%s/pulse%0d", tag, i), 64'(b0.net_valid), 64'(1));
            chk($sformatf("%s/pkt%0d", tag, i), 64'(b0.net_pkt),
                64'(pkt0(rw, m, a, (i < PMAX0) ? i : PMAX0, d)));
            @(negedge clk);
            if (k == K_SIL) begin
                repeat (TMO0 - 1) @(negedge clk);
                chk($sformatf("%s/silent%0d", tag, i), 64'({b0.net_valid, b0.resp_valid}), 64'(0));
            end else begin
                repeat (a_dly[i]) @(negedge clk);
                b0.net_back_valid = (k != K_DROP);
                b0.net_back_pkt   = {(k == K_SUC || k == K_DSUC), a_bd[i]};
                b0.net_dropped    = (k == K_DROP || k == K_DSUC || k == K_NDROP);
            end
            @(negedge clk);
            b0.net_back_valid = 1'b0;
            b0.net_dropped    = 1'b0;
            fin = (i == n - 1);
            chk($sformatf("%s/next_net%0d", tag, i), 64'(b0.net_valid), 64'(!fin));
            chk($sformatf("%s/next_resp%0d", tag, i), 64'(b0.resp_valid), 64'(fin));
        end
        chk({tag, "/ok"}, 64'(b0.resp_ok), 64'(ok));
        chk({tag, "/data"}, 64'(b0.resp_data), 64'(rdata));
        chk({tag, "/lat"}, 64'(b0.resp_latency), 64'(lat));
        chk({tag, "/stat_retries"}, 64'(b0.stat_retries), 64'(m_retries));
        chk({tag, "/stat_failures"}, 64'(b0.stat_failures), 64'(m_failures));
        @(negedge clk);
        chk({tag, "/resp_one_cycle"}, 64'(b0.resp_valid), 64'(0));
        chk({tag, "/ready_again"}, 64'(b0.req_ready), 64'(1));
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        b0.req_valid = 1'b0; b0.req_rw = 1'b0; b0.req_mod_id = '0; b0.req_local_addr = '0; b0.req_data = '0;
        b0.net_back_pkt = '0; b0.net_back_valid = 1'b0; b0.net_dropped = 1'b0;
        b1.req_valid = 1'b0; b1.req_rw = 1'b0; b1.req_mod_id = '0; b1.req_local_addr = '0; b1.req_data = '0;
        b1.net_back_pkt = '0; b1.net_back_valid = 1'b0; b1.net_dropped = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst/req_ready", 64'(b0.req_ready), 64'(1));
        chk("rst/net", 64'({b0.net_valid, b0.net_pkt}), 64'(0));
        chk("rst/resp", 64'({b0.resp_valid, b0.resp_ok, b0.resp_data, b0.resp_latency}), 64'(0));
        chk("rst/stats", 64'({b0.stat_retries, b0.stat_failures}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single-shot read, SUC three cycles after the issue pulse.
        set_att(0, K_SUC, 2, 8'hA5);
        run_req(1'b0, 2'd3, 8'h12, 8'h00, "t1");
        chk("t1/lat_const", 64'(b0.resp_latency), 64'(4));

        // Write: two NACKs then SUC.
        set_att(0, K_NACK, 1, 8'h11); set_att(1, K_NACK, 0, 8'h22); set_att(2, K_SUC, 3, 8'h5C);
        run_req(1'b1, 2'd1, 8'h40, 8'h9E, "t2");

        // NACK every time: priority saturates, then give up.
        for (int i = 0; i <= MAXR0; i++) set_att(i, K_NACK, i, 8'hFF);
        run_req(1'b0, 2'd2, 8'h7F, 8'h00, "t3");

        // Drop alone retries; drop with SUC is a success; NACK with drop is one failure.
        set_att(0, K_DROP, 0, 8'h00); set_att(1, K_DSUC, 1, 8'h3C);
        run_req(1'b1, 2'd0, 8'h01, 8'h77, "t4a");
        set_att(0, K_DSUC, 0, 8'hC3);
        run_req(1'b0, 2'd1, 8'h02, 8'h00, "t4b");
        set_att(0, K_NDROP, 2, 8'h00); set_att(1, K_SUC, TMO0 - 1, 8'h81);
        run_req(1'b1, 2'd3, 8'hFE, 8'h18, "t4c");

        // Silent network: timeout after TMO0 WAIT cycles.
        set_att(0, K_SIL, 0, 8'h00); set_att(1, K_SUC, 0, 8'h66);
        run_req(1'b0, 2'd2, 8'h33, 8'h00, "t5a");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i <= MAXR0; i++)
                set_att(i, int'($urandom_range(0, 5)), int'($urandom_range(0, TMO0 - 1)),
                        DW'($urandom_range(0, 255)));
            run_req(1'($urandom_range(0, 1)), MB'($urandom_range(0, 3)), AB'($urandom_range(0, 255)),
                    DW'($urandom_range(0, 255)), $sformatf("rnd%0d", r));
        end

        // TIMEOUT=0 instance never times out.
        b1.req_valid = 1'b1; b1.req_rw = 1'b1; b1.req_mod_id = 2'd1; b1.req_local_addr = 8'h5A; b1.req_data = 8'hC0;
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("t5b/pulse", 64'(b1.net_valid), 64'(1));
        chk("t5b/pkt", 64'(b1.net_pkt), 64'(pkt1(1'b1, 2'd1, 8'h5A, 8'hC0)));
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b1.net_valid || b1.resp_valid || b1.req_ready) cnt++;
        end
        chk("t5b/silent_200", 64'(cnt), 64'(0));

        // Reset in the middle of WAIT.
        b0.req_valid = 1'b1; b0.req_rw = 1'b0; b0.req_mod_id = 2'd2; b0.req_local_addr = 8'h44; b0.req_data = 8'h00;
        @(negedge clk);
        b0.req_valid = 1'b0;
        chk("t6/pulse", 64'(b0.net_valid), 64'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6/async_net", 64'({b0.net_valid, b0.net_pkt}), 64'(0));
        chk("t6/async_resp", 64'({b0.resp_valid, b0.resp_ok, b0.resp_data, b0.resp_latency}), 64'(0));
        chk("t6/async_ready", 64'(b0.req_ready), 64'(1));
        chk("t6/async_stats", 64'({b0.stat_retries, b0.stat_failures}), 64'(0));
        m_retries = 0;
        m_failures = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        b0.net_back_valid = 1'b1; b0.net_back_pkt = {1'b1, 8'hEE};
        @(negedge clk);
        b0.net_back_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (b0.resp_valid || b0.net_valid || !b0.req_ready) cnt++;
            @(negedge clk);
        end
        chk("t6/stray_back_ignored", 64'(cnt), 64'(0));
        set_att(0, K_SUC, 1, 8'h0D);
        run_req(1'b1, 2'd0, 8'h99, 8'h42, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
